// File: rtl/hazard_controller_pkg.sv
// Shared state encoding and hazard-detection helper for the pipeline hazard controller.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // A load in EX whose destination feeds the ID instruction; x0 never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_r_en,
        input logic [4:0] ex_reg_dst,
        input logic [4:0] id_rs1,
        input logic       id_uses_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs2
    );
        logic hit1;
        logic hit2;
        hit1 = id_uses_rs1 && (id_rs1 == ex_reg_dst);
        hit2 = id_uses_rs2 && (id_rs2 == ex_reg_dst);
        return ex_mem_r_en && (ex_reg_dst != 5'd0) && (hit1 || hit2);
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_value
);

    logic [W-1:0] value_q;

    // Count qualified events, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            value_q <= '0;
        end else if (i_inc && (value_q != {W{1'b1}})) begin
            value_q <= value_q + W'(1);
        end
    end

    assign o_value = value_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory-wait freezes,
// a memory-timeout watchdog and saturating performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic             i_ex_mem_r_en,
    input  logic [4:0]       i_ex_reg_dst,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic [WCNT_W-1:0] wcnt_nxt_s;
    logic              timeout_q;
    logic              timeout_d;
    logic              load_use_s;
    logic              mem_wait_s;

    assign load_use_s = load_use_hazard(i_ex_mem_r_en, i_ex_reg_dst, i_id_rs1, i_id_uses_rs1,
                                        i_id_rs2, i_id_uses_rs2);
    assign mem_wait_s = i_mem_req && !i_mem_ready;

    // Zero-latency pipeline control: memory freeze, then branch flush, then load-use stall.
    always_comb begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        if (i_rst || (state_q == HALT)) begin
            o_pc_en = 1'b0;
        end else if (mem_wait_s) begin
            o_pc_en = 1'b0;
        end else if (i_ex_branch_taken) begin
            o_pc_en        = 1'b1;
            o_if_id_en     = 1'b1;
            o_if_id_flush  = 1'b1;
            o_id_ex_en     = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_en    = 1'b1;
            o_mem_wb_en    = 1'b1;
        end else if (load_use_s) begin
            // ID/EX still loads, but with the bubble so the stalled instruction is not issued twice.
            o_id_ex_en     = 1'b1;
            o_id_ex_bubble = 1'b1;
            o_ex_mem_en    = 1'b1;
            o_mem_wb_en    = 1'b1;
        end else begin
            o_pc_en     = 1'b1;
            o_if_id_en  = 1'b1;
            o_id_ex_en  = 1'b1;
            o_ex_mem_en = 1'b1;
            o_mem_wb_en = 1'b1;
        end
    end

    // Next-state and watchdog: the counter value is the number of frozen cycles including this one.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        timeout_d  = timeout_q;
        wcnt_nxt_s = (state_q == RUN) ? WCNT_ONE : (wcnt_q + WCNT_ONE);
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait_s) begin
                    if (wcnt_nxt_s >= TIMEOUT_C) begin
                        state_d   = HALT;
                        wcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                        wcnt_d  = wcnt_nxt_s;
                    end
                end else begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            HALT: begin
                state_d   = HALT;
                timeout_d = 1'b1;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (!o_pc_en),
        .o_value (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (o_if_id_flush),
        .o_value (o_flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed table-driven bench for hazard_controller plus hand-written multi-cycle sequences.
module tb_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Expected control bundle order: {pc, if_id_en, if_id_flush, id_ex_en, bubble, ex_mem, mem_wb}
    localparam logic [6:0] NORM   = 7'b1101011;
    localparam logic [6:0] STALL  = 7'b0001111;
    localparam logic [6:0] FLUSH  = 7'b1111111;
    localparam logic [6:0] FREEZE = 7'b0000000;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [4:0]       i_id_rs1, i_id_rs2, i_ex_reg_dst;
    logic             i_id_uses_rs1, i_id_uses_rs2, i_ex_mem_r_en;
    logic             i_ex_branch_taken, i_mem_req, i_mem_ready;
    logic             o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_bubble;
    logic             o_ex_mem_en, o_mem_wb_en, o_mem_timeout;
    logic [CNT_W-1:0] o_stall_cycles, o_flush_count;
    logic [6:0]       ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[12];

    hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_id_rs1          (i_id_rs1),
        .i_id_rs2          (i_id_rs2),
        .i_id_uses_rs1     (i_id_uses_rs1),
        .i_id_uses_rs2     (i_id_uses_rs2),
        .i_ex_mem_r_en     (i_ex_mem_r_en),
        .i_ex_reg_dst      (i_ex_reg_dst),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_mem_req         (i_mem_req),
        .i_mem_ready       (i_mem_ready),
        .o_pc_en           (o_pc_en),
        .o_if_id_en        (o_if_id_en),
        .o_if_id_flush     (o_if_id_flush),
        .o_id_ex_en        (o_id_ex_en),
        .o_id_ex_bubble    (o_id_ex_bubble),
        .o_ex_mem_en       (o_ex_mem_en),
        .o_mem_wb_en       (o_mem_wb_en),
        .o_mem_timeout     (o_mem_timeout),
        .o_stall_cycles    (o_stall_cycles),
        .o_flush_count     (o_flush_count)
    );

    always #5 i_clk = ~i_clk;

    assign ctrl = {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_bubble,
                   o_ex_mem_en, o_mem_wb_en};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic ld, input logic [4:0] rd, input logic br,
                         input logic req, input logic rdy);
        i_id_rs1          = rs1;
        i_id_rs2          = rs2;
        i_id_uses_rs1     = u1;
        i_id_uses_rs2     = u2;
        i_ex_mem_r_en     = ld;
        i_ex_reg_dst      = rd;
        i_ex_branch_taken = br;
        i_mem_req         = req;
        i_mem_ready       = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, STALL};
        vecs[1]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[2]  = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NORM};
        vecs[3]  = '{5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, STALL};
        vecs[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[5]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[6]  = '{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, NORM};
        vecs[7]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, FREEZE};
        vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, STALL};
        vecs[9]  = '{5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM};
        vecs[10] = '{5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, STALL};
        vecs[11] = '{5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, NORM};

        // Reset: outputs low even with a branch and load-use present.
        i_rst = 1'b1;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        repeat (2) next_cycle();
        chk("reset_ctrl", 32'(ctrl), 32'(FREEZE));
        chk("reset_stall", 32'(o_stall_cycles), 32'd0);
        chk("reset_flush", 32'(o_flush_count), 32'd0);
        chk("reset_timeout", 32'(o_mem_timeout), 32'd0);
        i_rst = 1'b0;
        idle();
        #2;
        chk("post_reset_ctrl", 32'(ctrl), 32'(NORM));
        next_cycle();

        // Table: combinational priority in RUN and through a brief MEM_WAIT.
        begin
            int exp_stall;
            int exp_flush;
            exp_stall = 0;
            exp_flush = 0;
            pulse_reset();
            for (int i = 0; i < 12; i++) begin
                drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].ld,
                      vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
                #2;
                chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp));
                if (vecs[i].exp[6] == 1'b0) exp_stall++;
                if (vecs[i].exp[4] == 1'b1) exp_flush++;
                next_cycle();
            end
            idle();
            #2;
            chk("table_stall_cnt", 32'(o_stall_cycles), 32'(exp_stall));
            chk("table_flush_cnt", 32'(o_flush_count), 32'(exp_flush));
        end

        // One-cycle load-use stall, then the pipeline moves again.
        pulse_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #2;
        chk("lu_stall", 32'(ctrl), 32'(STALL));
        next_cycle();
        drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        #2;
        chk("lu_resume", 32'(ctrl), 32'(NORM));
        chk("lu_stall_cnt", 32'(o_stall_cycles), 32'd1);

        // Branch with load-use: flush wins, stall count unchanged.
        next_cycle();
        pulse_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #2;
        chk("br_lu_ctrl", 32'(ctrl), 32'(FLUSH));
        next_cycle();
        idle();
        chk("br_lu_flush_cnt", 32'(o_flush_count), 32'd1);
        chk("br_lu_stall_cnt", 32'(o_stall_cycles), 32'd0);

        // Three-cycle memory wait with a branch pending; flush fires on the ready cycle.
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            #2;
            chk($sformatf("mw_freeze%0d", c), 32'(ctrl), 32'(FREEZE));
            next_cycle();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        #2;
        chk("mw_ready_flush", 32'(ctrl), 32'(FLUSH));
        chk("mw_flush_pre", 32'(o_flush_count), 32'd0);
        next_cycle();
        idle();
        chk("mw_stall_cnt", 32'(o_stall_cycles), 32'd3);
        chk("mw_flush_cnt", 32'(o_flush_count), 32'd1);
        chk("mw_timeout", 32'(o_mem_timeout), 32'd0);

        // Watchdog: four frozen cycles, then HALT; a late ready is ignored.
        pulse_reset();
        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            #2;
            chk($sformatf("wd_freeze%0d", c), 32'(ctrl), 32'(FREEZE));
            chk($sformatf("wd_no_timeout%0d", c), 32'(o_mem_timeout), 32'd0);
            next_cycle();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("wd_timeout", 32'(o_mem_timeout), 32'd1);
        chk("wd_halt_ctrl", 32'(ctrl), 32'(FREEZE));
        next_cycle();
        idle();
        #2;
        chk("wd_halt_sticky", 32'(o_mem_timeout), 32'd1);
        chk("wd_halt_idle_ctrl", 32'(ctrl), 32'(FREEZE));
        chk("wd_stall_cnt", 32'(o_stall_cycles), 32'd5);
        i_rst = 1'b1;
        #1;
        chk("wd_async_timeout", 32'(o_mem_timeout), 32'd0);
        chk("wd_async_stall", 32'(o_stall_cycles), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("wd_after_reset_ctrl", 32'(ctrl), 32'(NORM));
        next_cycle();

        // Saturation: 20 stall cycles on a 4-bit counter hold at 15.
        pulse_reset();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (20) next_cycle();
        chk("sat_stall_cnt", 32'(o_stall_cycles), 32'd15);
        idle();
        next_cycle();
        chk("sat_stall_hold", 32'(o_stall_cycles), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
